brick_game_ctrl: RTL and testbench

BRICK_GAME_CTRL -- requirements
Module: brick_game_ctrl

---
 rtl/brick_game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_brick_game_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/brick_game_ctrl.sv
// brick_game_ctrl: game-flow controller for a 10-block breakout game.
// Tracks block state, score, lives and ball direction, and gates ball motion.
// Every decision is taken on frame_tick cycles; all outputs are registered.
// Optional feature: define BRICK_SPEEDUP_EN to make the ball faster as the
// score grows. Without it, ball_step is a constant 1.
// Ports:
//   clk, rst (async, active-low), frame_tick, start, collide_paddle,
//   collide_block[9:0], ball_miss                          -> inputs
//   block_alive[9:0], ball_dy_up, ball_run, ball_reset,
//   ball_step[2:0], score[7:0], lives[1:0], state[2:0]      -> outputs
module brick_game_ctrl #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned COOLDOWN_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collide_paddle,
  input  logic [9:0] collide_block,
  input  logic       ball_miss,
  output logic [9:0] block_alive,
  output logic       ball_dy_up,
  output logic       ball_run,
  output logic       ball_reset,
  output logic [2:0] ball_step,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int unsigned NBLK = 10;
  localparam int unsigned CD_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_WON   = 3'd3,
    S_LOST  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [NBLK-1:0] alive_q, alive_d;
  logic            dy_q, dy_d;
  logic            run_q, run_d;
  logic            rstp_q, rstp_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [NBLK-1:0] hit, hit_low;

  // Only blocks still alive can be hit; isolate the lowest-index hit.
  assign hit     = collide_block & alive_q;
  assign hit_low = hit & (~hit + NBLK'(1));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    dy_d    = dy_q;
    score_d = score_q;
    lives_d = lives_q;
    cd_d    = cd_q;
    rstp_d  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SERVE;
            lives_d = 2'(LIVES_INIT);
            score_d = 8'd0;
            alive_d = '1;
            rstp_d  = 1'b1;
          end
        end
        S_SERVE: begin
          if (start) begin
            state_d = S_PLAY;
            dy_d    = 1'b1;
          end
        end
        S_PLAY: begin
          if (ball_miss) begin
            // A miss overrides any hit on the same frame.
            cd_d   = '0;
            rstp_d = 1'b1;
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              state_d = S_SERVE;
            end else begin
              lives_d = 2'd0;
              state_d = S_LOST;
            end
          end else if ((hit != '0) && (cd_q == '0)) begin
            alive_d = alive_q & ~hit_low;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            dy_d    = ~dy_q;
            cd_d    = CD_W'(COOLDOWN_FRAMES);
            if (alive_d == '0) begin
              state_d = S_WON;
              cd_d    = '0;
            end
          end else if (collide_paddle && (cd_q == '0)) begin
            dy_d = 1'b1;
            cd_d = CD_W'(COOLDOWN_FRAMES);
          end else if (cd_q != '0) begin
            cd_d = cd_q - CD_W'(1);
          end
        end
        S_WON, S_LOST: begin
          if (!start) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    run_d = (state_d == S_PLAY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      alive_q <= '1;
      dy_q    <= 1'b1;
      run_q   <= 1'b0;
      rstp_q  <= 1'b0;
      score_q <= 8'd0;
      lives_q <= 2'(LIVES_INIT);
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      dy_q    <= dy_d;
      run_q   <= run_d;
      rstp_q  <= rstp_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cd_q    <= cd_d;
    end
  end

`ifdef BRICK_SPEEDUP_EN
  logic [2:0] step_q, step_d;

  // Step = 1 + floor(score/3), capped at 4; follows the score register.
  always_comb begin
    step_d = 3'd1;
    if (score_d >= 8'd9)      step_d = 3'd4;
    else if (score_d >= 8'd6) step_d = 3'd3;
    else if (score_d >= 8'd3) step_d = 3'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= 3'd1;
    else      step_q <= step_d;
  end

  assign ball_step = step_q;
`else
  assign ball_step = 3'd1;
`endif

  assign block_alive = alive_q;
  assign ball_dy_up  = dy_q;
  assign ball_run    = run_q;
  assign ball_reset  = rstp_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign state       = state_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Directed self-checking bench for brick_game_ctrl (default parameters).
module tb_brick_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       collide_paddle = 1'b0;
  logic [9:0] collide_block = 10'h000;
  logic       ball_miss = 1'b0;
  logic [9:0] block_alive;
  logic       ball_dy_up, ball_run, ball_reset;
  logic [2:0] ball_step;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  brick_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .collide_paddle(collide_paddle), .collide_block(collide_block),
    .ball_miss(ball_miss), .block_alive(block_alive), .ball_dy_up(ball_dy_up),
    .ball_run(ball_run), .ball_reset(ball_reset), .ball_step(ball_step),
    .score(score), .lives(lives), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: frame_tick high for exactly one rising edge, sample 1 time unit later.
  task automatic frame();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_step(input int k);
`ifdef BRICK_SPEEDUP_EN
    return (k >= 9) ? 3'd4 : 3'(1 + k / 3);
`else
    return 3'd1;
`endif
  endfunction

  logic [9:0] exp_alive;

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_alive", block_alive, 10'h3FF);
    chk("rst_dy", ball_dy_up, 1);
    chk("rst_run", ball_run, 0);
    chk("rst_breset", ball_reset, 0);
    chk("rst_step", ball_step, 1);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    @(posedge clk); #1 rst = 1'b1;

    // Start without frame_tick is ignored.
    start = 1'b1;
    idle_clk();
    chk("ignore_start", state, 0);

    // IDLE -> SERVE
    frame();
    chk("serve_state", state, 1);
    chk("serve_lives", lives, 3);
    chk("serve_alive", block_alive, 10'h3FF);
    chk("serve_breset", ball_reset, 1);
    chk("serve_run", ball_run, 0);
    idle_clk();
    chk("breset_pulse_end", ball_reset, 0);

    // SERVE -> PLAY
    frame();
    chk("play_state", state, 2);
    chk("play_run", ball_run, 1);
    chk("play_dy", ball_dy_up, 1);
    chk("breset_once", ball_reset, 0);
    start = 1'b0;

    // Collision with frame_tick low is ignored.
    collide_block = 10'h021;
    idle_clk();
    chk("ignore_blk", block_alive, 10'h3FF);

    // Block hit: lowest set bit only.
    frame();
    chk("hit1_alive", block_alive, 10'h3FE);
    chk("hit1_score", score, 1);
    chk("hit1_dy", ball_dy_up, 0);
    frame();
    chk("cd1_alive", block_alive, 10'h3FE);
    chk("cd1_score", score, 1);
    chk("cd1_dy", ball_dy_up, 0);
    frame();
    chk("cd2_alive", block_alive, 10'h3FE);
    collide_block = 10'h000;

    // Paddle alone forces dy up.
    collide_paddle = 1'b1;
    frame();
    chk("pad_dy", ball_dy_up, 1);
    collide_paddle = 1'b0;
    frame();
    frame();

    // Paddle and block together: block wins, dy toggles to 0.
    collide_paddle = 1'b1;
    collide_block  = 10'h004;
    frame();
    chk("pri_alive", block_alive, 10'h3FA);
    chk("pri_dy", ball_dy_up, 0);
    chk("pri_score", score, 2);
    collide_paddle = 1'b0;
    collide_block  = 10'h000;
    frame();
    frame();

    // Misses: 3 -> 2 -> 1 -> LOST.
    ball_miss = 1'b1;
    frame();
    chk("miss1_state", state, 1);
    chk("miss1_lives", lives, 2);
    chk("miss1_breset", ball_reset, 1);
    chk("miss1_run", ball_run, 0);
    ball_miss = 1'b0;
    start = 1'b1;
    frame();
    chk("reserve_state", state, 2);
    start = 1'b0;
    ball_miss = 1'b1;
    frame();
    chk("miss2_lives", lives, 1);
    ball_miss = 1'b0;
    start = 1'b1;
    frame();
    start = 1'b0;
    ball_miss = 1'b1;
    collide_block = 10'h001;
    frame();
    chk("lost_state", state, 4);
    chk("lost_lives", lives, 0);
    chk("lost_alive", block_alive, 10'h3FA);
    chk("lost_score", score, 2);
    ball_miss = 1'b0;
    collide_block = 10'h000;

    // LOST holds while start=1, returns to IDLE on start=0 keeping results.
    start = 1'b1;
    frame();
    chk("lost_hold", state, 4);
    start = 1'b0;
    frame();
    chk("lost_idle", state, 0);
    chk("idle_score_hold", score, 2);
    chk("idle_alive_hold", block_alive, 10'h3FA);

    // New game, then clear all ten blocks.
    start = 1'b1;
    frame();
    chk("g2_score", score, 0);
    chk("g2_alive", block_alive, 10'h3FF);
    chk("g2_lives", lives, 3);
    frame();
    chk("g2_play", state, 2);
    start = 1'b0;
    collide_block = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      frame();
      exp_alive = 10'h3FF << (i + 1);
      chk("clr_alive", block_alive, exp_alive);
      chk("clr_score", score, i + 1);
      chk("clr_dy", ball_dy_up, ((i + 1) % 2 == 0) ? 1 : 0);
      chk("clr_step", ball_step, exp_step(i + 1));
      chk("clr_state", state, (i == 9) ? 3 : 2);
      if (i < 9) begin
        frame();
        frame();
        chk("clr_cd_alive", block_alive, exp_alive);
      end
    end
    chk("won_run", ball_run, 0);
    chk("won_lives", lives, 3);
    collide_block = 10'h000;
    frame();
    chk("won_idle", state, 0);
    chk("won_score_hold", score, 10);

    // Third game, reset mid-PLAY at score 5.
    start = 1'b1;
    frame();
    chk("g3_step", ball_step, 1);
    frame();
    start = 1'b0;
    collide_block = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      frame();
      if (i < 4) begin
        frame();
        frame();
      end
    end
    chk("g3_score", score, 5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_alive", block_alive, 10'h3FF);
    chk("mid_rst_run", ball_run, 0);
    @(posedge clk); #1 rst = 1'b1;
    frame();
    chk("post_rst_idle", state, 0);
    start = 1'b1;
    frame();
    chk("post_rst_serve", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
